// File: rtl/cam_pkg.sv
// -----------------------------------------------------------------------------
// cam_pkg
// Shared definitions for the content-addressable lookup table.
//   cam_op_e : request opcode carried on req_op
//              00 SEARCH, 01 WRITE, 10 DELETE, 11 FLUSH
// -----------------------------------------------------------------------------
package cam_pkg;

   typedef enum logic [1:0] {
      CAM_SEARCH = 2'b00,
      CAM_WRITE  = 2'b01,
      CAM_DELETE = 2'b10,
      CAM_FLUSH  = 2'b11
   } cam_op_e;

endpackage : cam_pkg

// File: rtl/cam_prio_enc.sv
// -----------------------------------------------------------------------------
// cam_prio_enc
// Lowest-index priority encoder for a DEPTH-bit request vector.
// Ports:
//   vec  in   DEPTH   request bits
//   idx  out  IDX_W   index of the lowest set bit, 0 when none is set
//   any  out  1       at least one bit of vec is set
// -----------------------------------------------------------------------------
module cam_prio_enc #(
   parameter  int DEPTH = 16,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0] vec,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // Scan from the top down so the lowest set bit is the last to be written.
   always_comb begin
      idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = IDX_W'(i);
         end
      end
   end

   assign any = |vec;

endmodule : cam_prio_enc

// File: rtl/cam_table.sv
// -----------------------------------------------------------------------------
// cam_table
// Small content-addressable table of DEPTH keys of WIDTH bits. One request is
// accepted every cycle and answered exactly one cycle later. The table
// contents change at the accepting edge, so back-to-back requests see each
// other's effects.
//
// Optional feature (compile-time macro):
//   CAM_MASK_EN  adds port req_mask; SEARCH compares only the key bits whose
//                mask bit is 1. WRITE and DELETE always compare exactly.
//
// Ports:
//   clk        in   1        rising-edge clock
//   rst_n      in   1        synchronous active-low reset
//   req_valid  in   1        request present this cycle
//   req_op     in   2        opcode (cam_pkg::cam_op_e)
//   req_key    in   WIDTH    key for the operation
//   req_mask   in   WIDTH    SEARCH compare enables (CAM_MASK_EN only)
//   req_ready  out  1        always 1
//   rsp_valid  out  1        response for the request accepted last cycle
//   rsp_hit    out  1        key found
//   rsp_idx    out  IDX_W    lowest hit index, or slot written
//   rsp_match  out  DEPTH    per-entry match vector (pre-update contents)
//   rsp_err    out  1        WRITE rejected because the table was full
//   full       out  1        all entries valid
//   empty      out  1        no entry valid
//   count      out  IDX_W+1  number of valid entries
// -----------------------------------------------------------------------------
module cam_table
   import cam_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 16,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   input  logic [1:0]       req_op,
   input  logic [WIDTH-1:0] req_key,
`ifdef CAM_MASK_EN
   input  logic [WIDTH-1:0] req_mask,
`endif
   output logic             req_ready,
   output logic             rsp_valid,
   output logic             rsp_hit,
   output logic [IDX_W-1:0] rsp_idx,
   output logic [DEPTH-1:0] rsp_match,
   output logic             rsp_err,
   output logic             full,
   output logic             empty,
   output logic [IDX_W:0]   count
);

   localparam logic [IDX_W:0] CNT_FULL = (IDX_W + 1)'(DEPTH);

   function automatic logic [IDX_W:0] count_ones(input logic [DEPTH-1:0] v);
      logic [IDX_W:0] n;
      n = '0;
      for (int i = 0; i < DEPTH; i++) begin
         n = n + {{IDX_W{1'b0}}, v[i]};
      end
      return n;
   endfunction

   // Table storage. Keys carry no reset: an entry is only meaningful while
   // its valid bit is set, and valid bits are always reset.
   logic [WIDTH-1:0] key_mem [DEPTH];
   logic [DEPTH-1:0] vld_mem;

   cam_op_e          op;
   logic [DEPTH-1:0] exact_vec;
   logic [DEPTH-1:0] srch_vec;
   logic [DEPTH-1:0] sel_vec;
   logic             hit_any;
   logic [IDX_W-1:0] hit_idx;
   logic             free_any;
   logic [IDX_W-1:0] free_idx;

   logic [DEPTH-1:0] vld_nxt;
   logic [IDX_W:0]   cnt_nxt;
   logic             wr_en;
   logic             hit_nxt;
   logic [IDX_W-1:0] idx_nxt;
   logic             err_nxt;

   logic             rsp_vld_p1;
   logic             rsp_hit_p1;
   logic [IDX_W-1:0] rsp_idx_p1;
   logic [DEPTH-1:0] rsp_match_p1;
   logic             rsp_err_p1;
   logic             full_p1;
   logic             empty_p1;
   logic [IDX_W:0]   count_p1;

   assign op        = cam_op_e'(req_op);
   assign req_ready = 1'b1;

   // ---- stage 0: compare against the pre-update table ----
   always_comb begin
      exact_vec = '0;
      srch_vec  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         exact_vec[i] = vld_mem[i] && (key_mem[i] == req_key);
`ifdef CAM_MASK_EN
         srch_vec[i]  = vld_mem[i] && (((key_mem[i] ^ req_key) & req_mask) == '0);
`else
         srch_vec[i]  = exact_vec[i];
`endif
      end
   end

   // The masked compare only applies to SEARCH; FLUSH reports no matches.
   always_comb begin
      sel_vec = exact_vec;
      if (op == CAM_SEARCH) begin
         sel_vec = srch_vec;
      end else if (op == CAM_FLUSH) begin
         sel_vec = '0;
      end
   end

   cam_prio_enc #(.DEPTH(DEPTH)) u_hit_enc (
      .vec (sel_vec),
      .idx (hit_idx),
      .any (hit_any)
   );

   cam_prio_enc #(.DEPTH(DEPTH)) u_free_enc (
      .vec (~vld_mem),
      .idx (free_idx),
      .any (free_any)
   );

   always_comb begin
      vld_nxt = vld_mem;
      wr_en   = 1'b0;
      hit_nxt = 1'b0;
      idx_nxt = '0;
      err_nxt = 1'b0;
      if (req_valid) begin
         case (op)
            CAM_SEARCH: begin
               hit_nxt = hit_any;
               idx_nxt = hit_idx;
            end
            CAM_WRITE: begin
               if (hit_any) begin
                  // Duplicate key: report the existing slot, store nothing.
                  hit_nxt = 1'b1;
                  idx_nxt = hit_idx;
               end else if (free_any) begin
                  wr_en             = 1'b1;
                  vld_nxt[free_idx] = 1'b1;
                  idx_nxt           = free_idx;
               end else begin
                  err_nxt = 1'b1;
               end
            end
            CAM_DELETE: begin
               vld_nxt = vld_mem & ~exact_vec;
               hit_nxt = hit_any;
               idx_nxt = hit_idx;
            end
            CAM_FLUSH: begin
               vld_nxt = '0;
            end
            default: begin
               vld_nxt = vld_mem;
            end
         endcase
      end
   end

   assign cnt_nxt = count_ones(vld_nxt);

   // ---- stage 1: table update and registered response ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_mem      <= '0;
         rsp_vld_p1   <= 1'b0;
         rsp_hit_p1   <= 1'b0;
         rsp_idx_p1   <= '0;
         rsp_match_p1 <= '0;
         rsp_err_p1   <= 1'b0;
         count_p1     <= '0;
         full_p1      <= 1'b0;
         empty_p1     <= 1'b1;
      end else begin
         vld_mem    <= vld_nxt;
         rsp_vld_p1 <= req_valid;
         count_p1   <= cnt_nxt;
         full_p1    <= (cnt_nxt == CNT_FULL);
         empty_p1   <= (cnt_nxt == '0);
         // Response fields hold their last value across idle cycles.
         if (req_valid) begin
            rsp_hit_p1   <= hit_nxt;
            rsp_idx_p1   <= idx_nxt;
            rsp_match_p1 <= sel_vec;
            rsp_err_p1   <= err_nxt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && wr_en) begin
         key_mem[free_idx] <= req_key;
      end
   end

   assign rsp_valid = rsp_vld_p1;
   assign rsp_hit   = rsp_hit_p1;
   assign rsp_idx   = rsp_idx_p1;
   assign rsp_match = rsp_match_p1;
   assign rsp_err   = rsp_err_p1;
   assign full      = full_p1;
   assign empty     = empty_p1;
   assign count     = count_p1;

endmodule : cam_table

// File: tb/tb_cam_table.sv
// -----------------------------------------------------------------------------
// tb_cam_table
// Self-checking bench for cam_table: directed scenarios followed by random
// traffic, every response compared against a behavioural table model.
// Define CAM_MASK_EN for both bench and RTL to exercise masked SEARCH.
// -----------------------------------------------------------------------------
module tb_cam_table;
   import cam_pkg::*;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;
   localparam int IDX_W = $clog2(DEPTH);
`ifdef CAM_MASK_EN
   localparam bit MASK_ON = 1'b1;
`else
   localparam bit MASK_ON = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req_valid;
   logic [1:0]       req_op;
   logic [WIDTH-1:0] req_key;
   logic [WIDTH-1:0] req_mask;
   logic             req_ready;
   logic             rsp_valid;
   logic             rsp_hit;
   logic [IDX_W-1:0] rsp_idx;
   logic [DEPTH-1:0] rsp_match;
   logic             rsp_err;
   logic             full;
   logic             empty;
   logic [IDX_W:0]   count;

   always #5 clk = ~clk;

   cam_table #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_op    (req_op),
      .req_key   (req_key),
`ifdef CAM_MASK_EN
      .req_mask  (req_mask),
`endif
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_hit   (rsp_hit),
      .rsp_idx   (rsp_idx),
      .rsp_match (rsp_match),
      .rsp_err   (rsp_err),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   int total = 0;
   int bad   = 0;

   // Behavioural model: a plain array of (key, valid) slots.
   logic [WIDTH-1:0] m_key [DEPTH];
   bit               m_vld [DEPTH];
   bit               e_hit;
   bit               e_err;
   int               e_idx;
   logic [DEPTH-1:0] e_match;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", tag, act, exp);
      end
   endtask

   function automatic int m_count();
      int n = 0;
      for (int i = 0; i < DEPTH; i++) n += m_vld[i] ? 1 : 0;
      return n;
   endfunction

   task automatic model_step(input int op, input logic [WIDTH-1:0] key, input logic [WIDTH-1:0] mask);
      logic [WIDTH-1:0] eff;
      int first_hit = -1;
      int first_free = -1;
      eff     = (MASK_ON && op == 0) ? mask : {WIDTH{1'b1}};
      e_match = '0;
      e_hit   = 0;
      e_err   = 0;
      e_idx   = 0;
      if (op != 3) begin
         for (int i = 0; i < DEPTH; i++)
            if (m_vld[i] && (((m_key[i] ^ key) & eff) == 0)) e_match[i] = 1'b1;
      end
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (e_match[i]) first_hit = i;
         if (!m_vld[i]) first_free = i;
      end
      case (op)
         0, 2: begin
            if (first_hit >= 0) begin e_hit = 1; e_idx = first_hit; end
            if (op == 2)
               for (int i = 0; i < DEPTH; i++) if (e_match[i]) m_vld[i] = 0;
         end
         1: begin
            if (first_hit >= 0) begin
               e_hit = 1; e_idx = first_hit;
            end else if (first_free >= 0) begin
               m_key[first_free] = key; m_vld[first_free] = 1; e_idx = first_free;
            end else begin
               e_err = 1;
            end
         end
         default: for (int i = 0; i < DEPTH; i++) m_vld[i] = 0;
      endcase
   endtask

   task automatic check_flags(input string tag);
      check({tag, ".count"}, count, m_count());
      check({tag, ".full"},  full,  m_count() == DEPTH);
      check({tag, ".empty"}, empty, m_count() == 0);
      check({tag, ".ready"}, req_ready, 1);
   endtask

   task automatic check_rsp(input string tag, input bit vld);
      check({tag, ".valid"}, rsp_valid, vld);
      check({tag, ".hit"},   rsp_hit,   e_hit);
      check({tag, ".idx"},   rsp_idx,   e_idx);
      check({tag, ".match"}, rsp_match, e_match);
      check({tag, ".err"},   rsp_err,   e_err);
      check_flags(tag);
   endtask

   task automatic do_req(input string tag, input int op, input logic [WIDTH-1:0] key,
                         input logic [WIDTH-1:0] mask);
      @(negedge clk);
      rst_n = 1; req_valid = 1; req_op = 2'(op); req_key = key; req_mask = mask;
      model_step(op, key, mask);
      @(posedge clk); #1;
      check_rsp(tag, 1);
   endtask

   task automatic do_idle(input string tag);
      @(negedge clk);
      rst_n = 1; req_valid = 0; req_op = 2'($urandom); req_key = WIDTH'($urandom);
      @(posedge clk); #1;
      check_rsp(tag, 0);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst_n = 0; req_valid = 1; req_op = 2'(CAM_WRITE); req_key = WIDTH'($urandom);
      for (int i = 0; i < DEPTH; i++) m_vld[i] = 0;
      e_hit = 0; e_err = 0; e_idx = 0; e_match = '0;
      @(posedge clk); #1;
      check_rsp(tag, 0);
   endtask

   localparam logic [WIDTH-1:0] ALL = {WIDTH{1'b1}};

   initial begin
      rst_n = 0; req_valid = 0; req_op = '0; req_key = '0; req_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin m_vld[i] = 0; m_key[i] = '0; end
      e_hit = 0; e_err = 0; e_idx = 0; e_match = '0;
      repeat (2) @(posedge clk);
      do_reset("rst0");

      // First write, search hit and search miss from an empty table.
      do_req("w00", 1, 8'h00, ALL);
      check("w00.count_lit", count, 1);
      do_req("s00", 0, 8'h00, ALL);
      check("s00.hit_lit", rsp_hit, 1);
      do_req("s01", 0, 8'h01, ALL);
      check("s01.match_lit", rsp_match, 0);

      // Write then immediately search: update visible one cycle later.
      do_req("fl0", 3, 8'h00, ALL);
      do_req("wA5", 1, 8'hA5, ALL);
      do_req("sA5", 0, 8'hA5, ALL);
      check("sA5.idx_lit", rsp_idx, 0);

      // Fill, overflow, duplicate.
      do_req("fl1", 3, 8'h00, ALL);
      for (int i = 0; i < DEPTH; i++) do_req("fill", 1, WIDTH'(8'h80 + i), ALL);
      check("fill.full_lit", full, 1);
      do_req("wovf", 1, 8'h55, ALL);
      check("wovf.err_lit", rsp_err, 1);
      check("wovf.count_lit", count, 16);
      do_req("wdup", 1, 8'h83, ALL);
      check("wdup.idx_lit", rsp_idx, 3);

      // Delete frees a hole that the next write reuses.
      do_req("fl2", 3, 8'h00, ALL);
      do_req("w10", 1, 8'h10, ALL);
      do_req("w20", 1, 8'h20, ALL);
      do_req("w30", 1, 8'h30, ALL);
      do_req("d20", 2, 8'h20, ALL);
      check("d20.idx_lit", rsp_idx, 1);
      do_req("dmiss", 2, 8'h77, ALL);
      do_req("w40", 1, 8'h40, ALL);
      check("w40.idx_lit", rsp_idx, 1);
      check("w40.count_lit", count, 3);
      do_req("w50", 1, 8'h50, ALL);
      do_req("w60", 1, 8'h60, ALL);
      do_idle("idle0");
      do_req("fl5", 3, 8'h10, ALL);
      check("fl5.empty_lit", empty, 1);

      // Reset in the middle of traffic.
      do_req("w11", 1, 8'h11, ALL);
      do_reset("rstmid");
      do_req("s11", 0, 8'h11, ALL);

`ifdef CAM_MASK_EN
      do_req("mfl", 3, 8'h00, ALL);
      do_req("mwA5", 1, 8'hA5, ALL);
      do_req("msF0", 0, 8'hAF, 8'hF0);
      check("msF0.hit_lit", rsp_hit, 1);
      do_req("msFF", 0, 8'hAF, 8'hFF);
      check("msFF.hit_lit", rsp_hit, 0);
      do_req("mwAF", 1, 8'hAF, 8'hF0);
      check("mwAF.idx_lit", rsp_idx, 1);
`endif

      // Random traffic over a small key space so hits and fills are common.
      for (int n = 0; n < 2000; n++) begin
         int r;
         int op;
         r = int'($urandom_range(0, 99));
         if (r < 2) begin
            do_reset("rnd.rst");
         end else if (r < 12) begin
            do_idle("rnd.idle");
         end else begin
            r = int'($urandom_range(0, 99));
            op = (r < 50) ? 1 : (r < 80) ? 0 : (r < 97) ? 2 : 3;
            do_req("rnd", op, WIDTH'($urandom_range(0, 23)), WIDTH'($urandom));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_cam_table
